// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch PC controller: sequential advance, branch/jump redirect,
// redirect buffering across stalls, halt, flush strobe and fetch counter.
module pc_fetch_ctrl #(
    parameter int                   N_BITS_DW = 32,
    parameter logic [N_BITS_DW-1:0] RESET_PC  = '0,
    parameter int                   PC_STEP   = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [N_BITS_DW-1:0] i_branch_target,
    input  logic                 i_jump,
    input  logic [N_BITS_DW-1:0] i_jump_target,
    input  logic                 i_halt,
    output logic [N_BITS_DW-1:0] o_pc,
    output logic [N_BITS_DW-1:0] o_pc_next,
    output logic                 o_flush,
    output logic                 o_halted,
    output logic                 o_misaligned,
    output logic [31:0]          o_instr_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t               state, state_d;
    logic [N_BITS_DW-1:0] pc_d;
    logic                 misaligned_d;
    logic [31:0]          count_d;
    logic                 pending_valid, pending_valid_d;
    logic [N_BITS_DW-1:0] pending_target, pending_target_d;

    logic                 active;
    logic                 req;
    logic [N_BITS_DW-1:0] req_target;
    logic                 apply_redirect;
    logic [N_BITS_DW-1:0] sel_target;

    assign o_pc_next = o_pc + N_BITS_DW'(PC_STEP);
    assign o_halted  = (state == HALTED);

    // Branch resolves in EX, so it is older than a jump in ID and wins.
    assign req        = i_branch_taken | i_jump;
    assign req_target = i_branch_taken ? i_branch_target : i_jump_target;
    assign active     = i_enable && (state == RUN);
    assign sel_target = req ? req_target : pending_target;

    always_comb begin
        state_d          = state;
        pc_d             = o_pc;
        misaligned_d     = o_misaligned;
        count_d          = o_instr_count;
        pending_valid_d  = pending_valid;
        pending_target_d = pending_target;
        apply_redirect   = 1'b0;
        o_flush          = 1'b0;

        if (active) begin
            if (i_stall) begin
                if (req) begin
                    pending_valid_d  = 1'b1;
                    pending_target_d = req_target;
                end
            end else begin
                apply_redirect = req | pending_valid;
                count_d        = o_instr_count + 32'd1;
                if (apply_redirect) begin
                    pc_d            = {sel_target[N_BITS_DW-1:2], 2'b00};
                    o_flush         = 1'b1;
                    pending_valid_d = 1'b0;
                    if (sel_target[1:0] != 2'b00)
                        misaligned_d = 1'b1;
                end else begin
                    pc_d = o_pc_next;
                    // A halt alongside a redirect is on the wrong path.
                    if (i_halt)
                        state_d = HALTED;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= RUN;
            o_pc           <= RESET_PC;
            o_misaligned   <= 1'b0;
            o_instr_count  <= '0;
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else begin
            state          <= state_d;
            o_pc           <= pc_d;
            o_misaligned   <= misaligned_d;
            o_instr_count  <= count_d;
            pending_valid  <= pending_valid_d;
            pending_target <= pending_target_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_target = '0;
    logic        i_halt = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_pc_next;
    logic        o_flush;
    logic        o_halted;
    logic        o_misaligned;
    logic [31:0] o_instr_count;

    int tests_run = 0;
    int tests_failed = 0;

    pc_fetch_ctrl #(.N_BITS_DW(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_jump(i_jump), .i_jump_target(i_jump_target), .i_halt(i_halt),
        .o_pc(o_pc), .o_pc_next(o_pc_next), .o_flush(o_flush), .o_halted(o_halted),
        .o_misaligned(o_misaligned), .o_instr_count(o_instr_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_stall = 0; i_branch_taken = 0; i_jump = 0; i_halt = 0;
        i_branch_target = '0; i_jump_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1; i_enable = 1;
        tick();
        i_reset = 0;
        #1;
    endtask

    task automatic test_reset();
        i_enable = 1; i_branch_taken = 1; i_branch_target = 32'h40; i_halt = 1;
        i_reset = 1;
        tick();
        i_reset = 0; idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp %h", o_pc, 32'h0); end
        tests_run++;
        if (o_halted !== 1'b0 || o_misaligned !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags halted=%b mis=%b exp 0 0", o_halted, o_misaligned);
        end
        tests_run++;
        if (o_instr_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", o_instr_count); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'(k * 4);
            tests_run++;
            if (o_pc !== exp_pc || o_flush !== 1'b0 || o_pc_next !== exp_pc + 32'd4) begin
                tests_failed++;
                $display("FAIL seq_step%0d pc=%h flush=%b next=%h exp pc=%h flush=0 next=%h",
                         k, o_pc, o_flush, o_pc_next, exp_pc, exp_pc + 32'd4);
            end
            tick();
        end
        tests_run++;
        if (o_pc !== 32'h10 || o_instr_count !== 32'd4) begin
            tests_failed++; $display("FAIL seq_end pc=%h count=%0d exp 00000010 4", o_pc, o_instr_count);
        end
    endtask

    task automatic test_priority();
        i_branch_taken = 1; i_branch_target = 32'h40;
        i_jump = 1; i_jump_target = 32'h80;
        #1;
        tests_run++;
        if (o_flush !== 1'b1) begin tests_failed++; $display("FAIL prio_flush got %b exp 1", o_flush); end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h40 || o_instr_count !== 32'd5) begin
            tests_failed++; $display("FAIL prio_target pc=%h count=%0d exp 00000040 5", o_pc, o_instr_count);
        end
        // jump alone
        i_jump = 1; i_jump_target = 32'h60;
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h60) begin tests_failed++; $display("FAIL jump_only pc=%h exp 00000060", o_pc); end
    endtask

    task automatic test_stall();
        i_stall = 1; i_jump = 1; i_jump_target = 32'h100;
        #1;
        tests_run++;
        if (o_flush !== 1'b0) begin tests_failed++; $display("FAIL stall_flush got %b exp 0", o_flush); end
        tick();
        i_jump = 0; i_jump_target = '0;
        tick();
        tick();
        tests_run++;
        if (o_pc !== 32'h60 || o_instr_count !== 32'd6) begin
            tests_failed++; $display("FAIL stall_hold pc=%h count=%0d exp 00000060 6", o_pc, o_instr_count);
        end
        i_stall = 0;
        #1;
        tests_run++;
        if (o_flush !== 1'b1) begin tests_failed++; $display("FAIL release_flush got %b exp 1", o_flush); end
        tick();
        tests_run++;
        if (o_pc !== 32'h100 || o_instr_count !== 32'd7) begin
            tests_failed++; $display("FAIL release_pc pc=%h count=%0d exp 00000100 7", o_pc, o_instr_count);
        end
        // newer pending request overwrites older
        i_stall = 1; i_jump = 1; i_jump_target = 32'h200;
        tick();
        i_jump = 0; i_branch_taken = 1; i_branch_target = 32'h300;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (o_pc !== 32'h300) begin tests_failed++; $display("FAIL pending_overwrite pc=%h exp 00000300", o_pc); end
        tick();
        tests_run++;
        if (o_pc !== 32'h304 || o_flush !== 1'b0) begin
            tests_failed++; $display("FAIL pending_cleared pc=%h flush=%b exp 00000304 0", o_pc, o_flush);
        end
    endtask

    task automatic test_wrap_misalign();
        i_branch_taken = 1; i_branch_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'hFFFF_FFFC || o_pc_next !== 32'h0) begin
            tests_failed++; $display("FAIL wrap_next pc=%h next=%h exp FFFFFFFC 00000000", o_pc, o_pc_next);
        end
        tick();
        tests_run++;
        if (o_pc !== 32'h0 || o_misaligned !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_pc pc=%h mis=%b exp 00000000 0", o_pc, o_misaligned);
        end
        i_branch_taken = 1; i_branch_target = 32'h46;
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h44 || o_misaligned !== 1'b1) begin
            tests_failed++; $display("FAIL misalign pc=%h mis=%b exp 00000044 1", o_pc, o_misaligned);
        end
        tick();
        tick();
        tests_run++;
        if (o_pc !== 32'h4C || o_misaligned !== 1'b1) begin
            tests_failed++; $display("FAIL misalign_sticky pc=%h mis=%b exp 0000004c 1", o_pc, o_misaligned);
        end
    endtask

    task automatic test_halt();
        do_reset();
        i_jump = 1; i_jump_target = 32'h20;
        tick();
        idle_inputs();
        i_halt = 1;
        #1;
        tests_run++;
        if (o_flush !== 1'b0) begin tests_failed++; $display("FAIL halt_flush got %b exp 0", o_flush); end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h24 || o_halted !== 1'b1 || o_instr_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL halt_enter pc=%h halted=%b count=%0d exp 00000024 1 2", o_pc, o_halted, o_instr_count);
        end
        i_branch_taken = 1; i_branch_target = 32'h40; i_jump = 1; i_jump_target = 32'h80;
        #1;
        tests_run++;
        if (o_flush !== 1'b0) begin tests_failed++; $display("FAIL halted_flush got %b exp 0", o_flush); end
        tick();
        i_enable = 0;
        tick();
        i_enable = 1;
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h24 || o_halted !== 1'b1 || o_instr_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL halted_frozen pc=%h halted=%b count=%0d exp 00000024 1 2", o_pc, o_halted, o_instr_count);
        end
        do_reset();
        tests_run++;
        if (o_halted !== 1'b0) begin tests_failed++; $display("FAIL halt_reset got %b exp 0", o_halted); end
        i_jump = 1; i_jump_target = 32'h20;
        tick();
        idle_inputs();
        i_halt = 1; i_branch_taken = 1; i_branch_target = 32'h8;
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (o_pc !== 32'h8 || o_halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_cancel pc=%h halted=%b exp 00000008 0", o_pc, o_halted);
        end
        tick();
        tests_run++;
        if (o_pc !== 32'hC) begin tests_failed++; $display("FAIL halt_cancel_run pc=%h exp 0000000c", o_pc); end
    endtask

    task automatic test_enable_reset();
        do_reset();
        tests_run++;
        if (o_misaligned !== 1'b0) begin tests_failed++; $display("FAIL mis_reset got %b exp 0", o_misaligned); end
        tick();
        i_enable = 0; i_branch_taken = 1; i_branch_target = 32'h40; i_halt = 1;
        #1;
        tests_run++;
        if (o_flush !== 1'b0) begin tests_failed++; $display("FAIL disabled_flush got %b exp 0", o_flush); end
        tick();
        tick();
        tests_run++;
        if (o_pc !== 32'h4 || o_halted !== 1'b0 || o_instr_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL disabled_frozen pc=%h halted=%b count=%0d exp 00000004 0 1", o_pc, o_halted, o_instr_count);
        end
        idle_inputs();
        i_enable = 1; i_stall = 1; i_jump = 1; i_jump_target = 32'h80;
        tick();
        i_jump = 0; i_jump_target = '0;
        i_reset = 1;
        tick();
        i_reset = 0;
        #1;
        tests_run++;
        if (o_pc !== 32'h0 || o_instr_count !== 32'd0) begin
            tests_failed++; $display("FAIL reset_midstall pc=%h count=%0d exp 00000000 0", o_pc, o_instr_count);
        end
        i_stall = 0;
        #1;
        tests_run++;
        if (o_flush !== 1'b0) begin tests_failed++; $display("FAIL pending_discard_flush got %b exp 0", o_flush); end
        tick();
        tests_run++;
        if (o_pc !== 32'h4) begin tests_failed++; $display("FAIL pending_discard pc=%h exp 00000004", o_pc); end
    endtask

    initial begin
        #2;
        test_reset();
        test_sequential();
        test_priority();
        test_stall();
        test_wrap_misalign();
        test_halt();
        test_enable_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch PC controller for the pipelined MIPS datapath. It owns the program-counter register that feeds instruction memory and advances it sequentially. It consumes the branch targets produced by the branch-offset adder and the jump targets from decode. Redirects requested while the pipeline is stalled are buffered, a halt freezes fetch, and a flush strobe plus a fetched-instruction counter are provided for the pipeline and debug unit.

## Interface
Parameters:
- N_BITS_DW, 32, PC and target width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential increment (bytes).

Ports:
- i_clock  in  1  system clock; all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug-unit run/step enable; 0 freezes all state.
- i_stall  in  1  hazard-unit stall; PC holds.
- i_branch_taken  in  1  EX-stage branch resolved taken.
- i_branch_target  in  N_BITS_DW  branch target (pc + sext(imm)<<2).
- i_jump  in  1  ID-stage jump request.
- i_jump_target  in  N_BITS_DW  jump target.
- i_halt  in  1  halt opcode detected in ID.
- o_pc  out  N_BITS_DW  registered PC to instruction memory.
- o_pc_next  out  N_BITS_DW  o_pc + PC_STEP, combinational.
- o_flush  out  1  combinational; redirect applied this cycle, flush IF/ID.
- o_halted  out  1  registered; fetch halted.
- o_misaligned  out  1  sticky; a target with nonzero bits [1:0] was taken.
- o_instr_count  out  32  number of accepted PC updates.

## Operation
- States: RUN, HALTED. Reset → RUN.
- Reset values: o_pc=RESET_PC, o_halted=0, o_misaligned=0, o_instr_count=0, pending_valid=0, pending_target=0. Reset overrides i_enable.
- Request this cycle: req = i_branch_taken | i_jump. Request target: i_branch_target if i_branch_taken, else i_jump_target. Branch wins over jump because it is the older instruction.
- i_enable=0 or state HALTED: nothing changes. Inputs are ignored, including redirect requests and i_halt. o_flush=0.
- RUN, enable=1, stall=1:
  - PC holds and the counter holds.
  - If req, pending_target is set to the request target and pending_valid to 1. A newer request overwrites an older pending one.
  - o_flush=0.
- RUN, enable=1, stall=0. The PC update, in priority order:
  1. If req, PC loads the request target.
  2. Else if pending_valid, PC loads pending_target.
  3. Else PC loads o_pc_next.
- RUN, enable=1, stall=0, side effects of the update:
  - In cases 1 and 2, o_flush=1 and pending_valid clears.
  - o_instr_count increments by 1 on every update (including redirects). It wraps at 2^32.
- Alignment: the loaded target has bits [1:0] forced to 0. If the original bits were nonzero, o_misaligned is set; it stays set until reset.
- Wrap-around: o_pc_next is computed modulo 2^N_BITS_DW, so 0xFFFFFFFC → 0x00000000.
- Halt: i_halt with enable=1, stall=0 and no applied redirect (neither case 1 nor case 2) moves the block to HALTED.
  - PC still advances for that edge and the counter increments.
  - o_halted=1 from the next cycle.
- Halt cancellation: if a redirect is applied in the same cycle as i_halt, the halt is on the wrong path. It is ignored and the block stays in RUN.
- i_halt while stalled is ignored. The ID stage re-presents it after the stall.
- HALTED exits only via i_reset.

## Timing
- o_pc, o_halted, o_misaligned and o_instr_count are registered and update one edge after the qualifying inputs.
- o_pc_next and o_flush are combinational from current state and inputs. No registered input-to-output path other than through o_pc.
- Redirect latency: the target appears on o_pc one cycle after the request when not stalled. Under stall, it appears one cycle after the first cycle with stall=0.
- A pending redirect is applied in the first non-stalled enabled cycle, even with no new request. o_flush is asserted in that cycle.
- Reset mid-stall with pending_valid=1: the pending redirect is discarded and o_pc=RESET_PC next cycle.

## Test plan
- Reset then 4 enabled cycles, no requests → o_pc 0,4,8,12,16; o_instr_count=4; o_flush always 0.
- At o_pc=0x10, i_branch_taken=1 with target 0x40 and i_jump=1 with target 0x80, same cycle → o_flush=1 that cycle; next o_pc=0x40.
- Stall for 3 cycles with i_jump target 0x100 in the first stall cycle, then release → o_pc holds through the stall. In the release cycle o_flush=1 with no live request; next o_pc=0x100; o_instr_count unchanged during the stall.
- o_pc=0xFFFFFFFC, no request → next o_pc=0x0. Branch target 0x00000046 → o_pc=0x44 and o_misaligned=1, which stays set until reset.
- i_halt at o_pc=0x20 → o_pc=0x24 and o_halted=1. Later requests or i_enable toggles leave o_pc=0x24. i_halt together with i_branch_taken target 0x8 → no halt; o_pc=0x8.
- i_enable=0 with i_branch_taken and i_halt asserted → no state change. Assert i_reset while pending_valid=1 → o_pc=RESET_PC and the pending redirect is never applied.
